// File: rtl/adc_frame_align_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_frame_align_ctrl: bitslip training, frame lock and gated lane data.  |
// | Option macro: ADC_LOCK_MONITOR_EN (lock monitoring and retrain)          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module adc_frame_align_ctrl #(
  parameter int          AdcChnls     = 8,
  parameter int          AdcWireMode  = 1,
  parameter int          AdcBits      = 12,
  parameter logic [15:0] FrmPattern   = 16'b0000111111000000,
  parameter int          SettleCycles = 4,
  parameter int          LockCount    = 16,
  parameter int          MissLimit    = 3
) (
  input  logic                                   FrmClk,
  input  logic                                   FrmRst_n,
  input  logic                                   BitClkDone,
  input  logic                                   ReAlign,
  input  logic [15:0]                            FrmWord,
  input  logic [16*AdcChnls*AdcWireMode-1:0]     LaneData,
  output logic                                   FrmBitslip,
  output logic                                   FrmAlignDone,
  output logic                                   FrmAlignErr,
  output logic [4:0]                             SlipCnt,
  output logic [7:0]                             LockLossCnt,
  output logic [16*AdcChnls*AdcWireMode-1:0]     AdcData,
  output logic [AdcChnls*AdcWireMode-1:0]        AdcDataValid
);

  localparam int         LANES       = AdcChnls * AdcWireMode;
  localparam int         FRM_W       = AdcBits / AdcWireMode;
  localparam logic [4:0] SLIP_MAX    = 5'(2 * FRM_W);
  localparam logic [3:0] SETTLE_LOAD = 4'(SettleCycles);
  localparam logic [7:0] LOCK_LAST   = 8'(LockCount - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_SLIP   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;
  localparam logic [2:0] ST_FAIL   = 3'd5;

  logic [2:0] state;
  logic [2:0] nxt;
  logic [7:0] match_cnt;
  logic [3:0] set_cnt;
  logic       match;
  logic       realign_go;
  logic       miss_trip;
  logic       unused_hi;

  assign match      = (FrmWord[FRM_W-1:0] == FrmPattern[FRM_W-1:0]);
  assign realign_go = BitClkDone && ReAlign && (state != ST_IDLE);
  assign unused_hi  = ^FrmWord[15:FRM_W];

`ifdef ADC_LOCK_MONITOR_EN
  localparam logic [3:0] MISS_LAST = 4'(MissLimit - 1);
  logic [3:0] miss_cnt;

  assign miss_trip = (state == ST_LOCKED) && !match && (miss_cnt == MISS_LAST);

  // A retrain started by ReAlign is not counted as a lock loss.
  always_ff @(posedge FrmClk) begin
    if (!FrmRst_n) begin
      miss_cnt    <= '0;
      LockLossCnt <= '0;
    end else begin
      miss_cnt <= (state == ST_LOCKED && nxt == ST_LOCKED && !match) ? miss_cnt + 4'd1 : 4'd0;
      if (state == ST_LOCKED && nxt == ST_CHECK && !realign_go && LockLossCnt != 8'hFF)
        LockLossCnt <= LockLossCnt + 8'd1;
    end
  end
`else
  assign miss_trip   = 1'b0;
  assign LockLossCnt = 8'd0;
`endif

  always_comb begin
    nxt = state;
    if (!BitClkDone) begin
      nxt = ST_IDLE;
    end else if (realign_go) begin
      nxt = ST_CHECK;
    end else begin
      case (state)
        ST_IDLE:   nxt = ST_CHECK;
        ST_CHECK: begin
          if (match) begin
            if (match_cnt == LOCK_LAST) nxt = ST_LOCKED;
          end else if (SlipCnt == SLIP_MAX) begin
            nxt = ST_FAIL;
          end else begin
            nxt = ST_SLIP;
          end
        end
        ST_SLIP:   nxt = ST_SETTLE;
        ST_SETTLE: if (set_cnt <= 4'd1) nxt = ST_CHECK;
        ST_LOCKED: if (miss_trip) nxt = ST_CHECK;
        ST_FAIL:   nxt = ST_FAIL;
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge FrmClk) begin
    if (!FrmRst_n) begin
      state        <= ST_IDLE;
      match_cnt    <= '0;
      set_cnt      <= '0;
      SlipCnt      <= '0;
      FrmBitslip   <= 1'b0;
      FrmAlignDone <= 1'b0;
      FrmAlignErr  <= 1'b0;
      AdcData      <= '0;
      AdcDataValid <= '0;
    end else begin
      state        <= nxt;
      FrmBitslip   <= (nxt == ST_SLIP);
      FrmAlignErr  <= (nxt == ST_FAIL);
      // Done rises one cycle after LOCKED is entered and drops as soon as it is left.
      FrmAlignDone <= (state == ST_LOCKED) && (nxt == ST_LOCKED);

      match_cnt <= (state == ST_CHECK && nxt == ST_CHECK && match && !realign_go)
                   ? match_cnt + 8'd1 : 8'd0;

      if (nxt == ST_SLIP)
        SlipCnt <= SlipCnt + 5'd1;
      else if (nxt == ST_IDLE || realign_go ||
               (nxt == ST_CHECK && (state == ST_IDLE || state == ST_LOCKED)))
        SlipCnt <= '0;

      if (nxt == ST_SETTLE && state == ST_SLIP)
        set_cnt <= SETTLE_LOAD;
      else if (nxt == ST_SETTLE)
        set_cnt <= set_cnt - 4'd1;
      else
        set_cnt <= '0;

      AdcData      <= FrmAlignDone ? LaneData : '0;
      AdcDataValid <= {LANES{FrmAlignDone}};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_align_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adc_frame_align_ctrl: directed self-checking bench for the aligner.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_adc_frame_align_ctrl;

  localparam int LANES = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   bit_clk_done;
  logic                   re_align;
  logic [15:0]            frm_word;
  logic [16*LANES-1:0]    lane_data;
  logic                   bitslip;
  logic                   done;
  logic                   err;
  logic [4:0]             slip_cnt;
  logic [7:0]             lock_loss;
  logic [16*LANES-1:0]    adc_data;
  logic [LANES-1:0]       adc_valid;

  always #5 clk = ~clk;

  adc_frame_align_ctrl dut (
    .FrmClk       (clk),
    .FrmRst_n     (rst_n),
    .BitClkDone   (bit_clk_done),
    .ReAlign      (re_align),
    .FrmWord      (frm_word),
    .LaneData     (lane_data),
    .FrmBitslip   (bitslip),
    .FrmAlignDone (done),
    .FrmAlignErr  (err),
    .SlipCnt      (slip_cnt),
    .LockLossCnt  (lock_loss),
    .AdcData      (adc_data),
    .AdcDataValid (adc_valid)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          slips   = 0;
  int          pulse_cyc[$];
  logic [11:0] pat     = 12'hFC0;
  logic        use_rot = 1'b0;
  int          rot0    = 0;
  int          slip_base = 0;
  logic [15:0] fixed_word = 16'h0FC0;

  function automatic logic [11:0] rotl12(input logic [11:0] v, input int n);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[10:0], r[11]};
    return r;
  endfunction

  // ISERDES stand-in: each bitslip undoes one bit of the initial rotation.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bitslip) begin
      slips = slips + 1;
      pulse_cyc.push_back(cyc);
    end
  end

  assign frm_word = use_rot
      ? {4'h0, rotl12(pat, ((slips - slip_base) >= rot0) ? 0 : rot0 - (slips - slip_base))}
      : fixed_word;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < limit);
  endtask

  task automatic pulse_realign;
    re_align = 1'b1;
    tick();
    re_align = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    int g1;
    int g2;
    int timeouts;

    rst_n        = 1'b0;
    bit_clk_done = 1'b0;
    re_align     = 1'b0;
    lane_data    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    repeat (3) tick();

    check("rst_done",   done,      0);
    check("rst_err",    err,       0);
    check("rst_slip",   slip_cnt,  0);
    check("rst_bslip",  bitslip,   0);
    check("rst_loss",   lock_loss, 0);
    check("rst_data",   adc_data,  0);
    check("rst_valid",  adc_valid, 0);

    // Aligned word: lock after 16 matches plus one cycle, no slips.
    rst_n        = 1'b1;
    bit_clk_done = 1'b1;
    base = pulse_cyc.size();
    tick();
    wait_done(100, n);
    check("t1_lock_lat",    n, 17);
    check("t1_done",        done, 1);
    check("t1_slip",        slip_cnt, 0);
    check("t1_no_pulse",    pulse_cyc.size() - base, 0);
    check("t1_valid_early", adc_valid, 0);
    tick();
    check("t1_data",        adc_data, lane_data);
    check("t1_valid",       adc_valid, 8'hFF);

    // Word rotated by 3: three slips six cycles apart, then lock.
    use_rot   = 1'b1;
    rot0      = 3;
    slip_base = slips;
    base      = pulse_cyc.size();
    pulse_realign();
    check("t2_realign_drop", done, 0);
    wait_done(300, n);
    check("t2_done",   done, 1);
    check("t2_pulses", pulse_cyc.size() - base, 3);
    check("t2_slip",   slip_cnt, 3);
    g1 = (pulse_cyc.size() >= base + 2) ? pulse_cyc[base+1] - pulse_cyc[base]   : -1;
    g2 = (pulse_cyc.size() >= base + 3) ? pulse_cyc[base+2] - pulse_cyc[base+1] : -1;
    check("t2_gap1", g1, 6);
    check("t2_gap2", g2, 6);

    // No valid word at all: 24 slips, then error.
    use_rot    = 1'b0;
    fixed_word = 16'h0000;
    base       = pulse_cyc.size();
    pulse_realign();
    n = 0;
    while (!err && n < 400) begin
      tick();
      n++;
    end
    check("t3_err",    err, 1);
    check("t3_done",   done, 0);
    check("t3_pulses", pulse_cyc.size() - base, 24);
    check("t3_slip",   slip_cnt, 24);
    repeat (10) tick();
    check("t3_hold_err",    err, 1);
    check("t3_hold_pulses", pulse_cyc.size() - base, 24);
    pulse_realign();
    check("t3_clr_err",  err, 0);
    check("t3_clr_slip", slip_cnt, 0);
    tick();
    check("t3_restart_pulse", bitslip, 1);
    check("t3_restart_slip",  slip_cnt, 1);

    // Relock for the monitoring tests.
    fixed_word = 16'h0FC0;
    pulse_realign();
    wait_done(200, n);
    check("t4_relock", done, 1);

`ifdef ADC_LOCK_MONITOR_EN
    fixed_word = 16'h0000;
    repeat (2) tick();
    fixed_word = 16'h0FC0;
    tick();
    check("t4_hold", done, 1);
    fixed_word = 16'h0000;
    repeat (3) tick();
    check("t4_loss_done", done, 0);
    check("t4_loss_cnt",  lock_loss, 1);
    tick();
    check("t4_loss_data",  adc_data, 0);
    check("t4_loss_valid", adc_valid, 0);
    timeouts = 0;
    for (int i = 2; i <= 300; i++) begin
      fixed_word = 16'h0FC0;
      wait_done(200, n);
      if (!done) timeouts++;
      fixed_word = 16'h0000;
      repeat (3) tick();
    end
    check("t4_timeouts", timeouts, 0);
    check("t4_sat",      lock_loss, 255);
    fixed_word = 16'h0FC0;
    wait_done(200, n);
`else
    timeouts = 0;
    fixed_word = 16'h0000;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!done) timeouts++;
    end
    check("t6_done_held", timeouts, 0);
    check("t6_loss",      lock_loss, 0);
    check("t6_valid",     adc_valid, 8'hFF);
    fixed_word = 16'h0FC0;
`endif

    // BitClkDone falls during SETTLE together with ReAlign.
    fixed_word = 16'h0000;
    pulse_realign();
    n = 0;
    while (!bitslip && n < 50) begin
      tick();
      n++;
    end
    check("t5_got_slip", bitslip, 1);
    tick();
    bit_clk_done = 1'b0;
    re_align     = 1'b1;
    base         = pulse_cyc.size();
    tick();
    re_align     = 1'b0;
    check("t5_done",  done, 0);
    check("t5_err",   err, 0);
    check("t5_bslip", bitslip, 0);
    repeat (20) tick();
    check("t5_no_pulse", pulse_cyc.size() - base, 0);
    check("t5_slip",     slip_cnt, 0);
    check("t5_valid",    adc_valid, 0);

    // Reset while locked clears everything at the next edge.
    fixed_word   = 16'h0FC0;
    bit_clk_done = 1'b1;
    wait_done(200, n);
    check("t5_lock", done, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_rst_done",  done, 0);
    check("t5_rst_valid", adc_valid, 0);
    check("t5_rst_data",  adc_data, 0);
    check("t5_rst_slip",  slip_cnt, 0);
    check("t5_rst_err",   err, 0);
    check("t5_rst_loss",  lock_loss, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_frame_align_ctrl.md
Name: adc_frame_align_ctrl

Overview:
Parametrised next-generation frame-alignment and lane-qualification controller for the ADC LVDS receive path. It runs in the frame (divided) clock domain and consumes the deserialised FCLK word and all deserialised data-lane words. It drives bitslip into the lane ISERDES, declares and monitors frame lock, retrains on loss of lock, and outputs gated, registered lane data with a per-lane valid flag.

Parameters:
AdcChnls, 8, ADC channels in package (1..16)
AdcWireMode, 1, lanes per channel (1 or 2); Lanes = AdcChnls*AdcWireMode
AdcBits, 12, sample width; FrmW = AdcBits/AdcWireMode bits compared per frame word
FrmPattern, 16'b0000111111000000, expected FCLK word; only FrmPattern[FrmW-1:0] compared
SettleCycles, 4, wait cycles after each bitslip pulse (1..15)
LockCount, 16, consecutive matches required to declare lock (1..255)
MissLimit, 3, consecutive mismatches while locked that force retrain (1..15)

Ports:
FrmClk  in  1  frame clock (ClkDiv domain)
FrmRst_n  in  1  reset, synchronous, active-low
BitClkDone  in  1  MMCM locked, level
ReAlign  in  1  single-cycle pulse, forces retrain
FrmWord  in  16  deserialised FCLK word, valid every cycle
LaneData  in  16*Lanes  deserialised lane words, lane i at [16i+15:16i]
FrmBitslip  out  1  one-cycle bitslip pulse to all ISERDES
FrmAlignDone  out  1  frame locked
FrmAlignErr  out  1  no match found within 2*FrmW slips
SlipCnt  out  5  slips issued in current training attempt
LockLossCnt  out  8  lock-loss events, saturating
AdcData  out  16*Lanes  registered lane data, zero when not locked
AdcDataValid  out  Lanes  per-lane valid

Behaviour:
- Reset (FrmRst_n=0 at FrmClk edge): state IDLE; all outputs 0; all counters 0.
- Match = (FrmWord[FrmW-1:0] == FrmPattern[FrmW-1:0]).
- IDLE: wait. BitClkDone=1 -> CHECK with MatchCnt=0, SlipCnt=0.
- CHECK, match: MatchCnt++. When MatchCnt reaches LockCount -> LOCKED; FrmAlignDone=1 from the next cycle.
- CHECK, mismatch: MatchCnt=0. If SlipCnt==2*FrmW -> FAIL, else -> SLIP.
- SLIP: exactly one cycle. FrmBitslip=1 and SlipCnt++. -> SETTLE with SetCnt=SettleCycles.
- SETTLE: FrmWord ignored. SetCnt decrements; at 0 -> CHECK.
- Bitslip spacing: minimum SettleCycles+2 cycles between pulses.
- LOCKED: consecutive-mismatch counter MissCnt; any match clears it. When MissCnt reaches MissLimit:
  - FrmAlignDone=0 next cycle.
  - LockLossCnt++ (saturates at 255).
  - SlipCnt=0, MatchCnt=0, -> CHECK.
- FAIL: FrmAlignErr=1; stays until ReAlign, BitClkDone fall, or reset.
- Priority, highest first: reset > BitClkDone=0 (any state -> IDLE; FrmAlignDone and FrmAlignErr clear next cycle) > ReAlign (from any non-IDLE state -> CHECK; SlipCnt, MatchCnt, MissCnt cleared; FrmAlignErr cleared; LockLossCnt kept) > normal transitions.
- ReAlign while in IDLE: ignored.
- Data path, one cycle latency:
  - AdcData <= FrmAlignDone ? LaneData : 0.
  - AdcDataValid <= {Lanes{FrmAlignDone}}.
  - Both use the registered FrmAlignDone, so the first valid data is the cycle after FrmAlignDone rises.
- SlipCnt: never exceeds 2*FrmW (5 bits covers FrmW<=12 at 2*FrmW=24; FrmW=16 is not supported).

Optional Feature:
ADC_LOCK_MONITOR_EN
- Defined: LOCKED-state mismatch monitoring, retrain and LockLossCnt behave as above.
- Undefined: LOCKED is terminal. FrmWord is ignored there; exit only via ReAlign, BitClkDone fall or reset. LockLossCnt is tied to 0 and MissCnt logic is removed.

Test Plan:
1. Reset, then BitClkDone=1, FrmWord=0x0FC0 constant -> no FrmBitslip; FrmAlignDone=1 exactly 17 cycles after entering CHECK (16 matches + 1); AdcData equals LaneData 1 cycle later; SlipCnt=0.
2. FrmWord rotated by 3 bits, rotating back one bit per slip -> exactly 3 bitslip pulses spaced 6 cycles apart; SlipCnt=3; lock then asserts.
3. FrmWord=0x0000 forever -> 24 pulses, then FrmAlignErr=1, FrmAlignDone=0; ReAlign pulse -> FrmAlignErr=0, SlipCnt=0, training restarts.
4. Locked, inject 2 mismatches then 1 match -> lock held. Inject 3 consecutive mismatches -> FrmAlignDone=0, LockLossCnt=1, AdcData=0, AdcDataValid=0 the following cycle. Repeat 300 times -> LockLossCnt=255.
5. BitClkDone falls mid-SETTLE together with a ReAlign pulse -> IDLE, no further bitslip, outputs cleared. FrmRst_n=0 while LOCKED -> all outputs 0 at the next edge.
6. ADC_LOCK_MONITOR_EN undefined, locked, FrmWord=0x0000 for 50 cycles -> FrmAlignDone stays 1, LockLossCnt=0.
